// File: rtl/cmd_arb_rr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_arb_rr_if                                                        |
// | Command-bus bundle for the round-robin arbiter: the packed upstream  |
// | master ports plus the single downstream slave port.                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface cmd_arb_rr_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_BITS   = 26,
  parameter int DATA_BITS   = 32
);
  // Upstream side: one lane per requesting master
  logic [NUM_MASTERS-1:0]           m_sel;
  logic [NUM_MASTERS-1:0]           m_rd_wr_n;
  logic [NUM_MASTERS*ADDR_BITS-1:0] m_byte_addr;
  logic [NUM_MASTERS*DATA_BITS-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]           m_ack;
  logic [NUM_MASTERS-1:0]           m_err;
  logic [DATA_BITS-1:0]             m_rdata;

  // Downstream side: the shared slave
  logic                             s_sel;
  logic                             s_rd_wr_n;
  logic [ADDR_BITS-1:0]             s_byte_addr;
  logic [DATA_BITS-1:0]             s_wdata;
  logic                             s_ack;
  logic [DATA_BITS-1:0]             s_rdata;

  // The arbiter's view: it serves the masters and drives the slave
  modport slave (
    input  m_sel, m_rd_wr_n, m_byte_addr, m_wdata,
    output m_ack, m_err, m_rdata,
    output s_sel, s_rd_wr_n, s_byte_addr, s_wdata,
    input  s_ack, s_rdata
  );

  // The environment's view: requesting masters plus the responding slave
  modport master (
    output m_sel, m_rd_wr_n, m_byte_addr, m_wdata,
    input  m_ack, m_err, m_rdata,
    input  s_sel, s_rd_wr_n, s_byte_addr, s_wdata,
    output s_ack, s_rdata
  );
endinterface
`default_nettype wire

// File: rtl/cmd_arb_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_arb_rr                                                           |
// | Round-robin arbiter merging NUM_MASTERS command-bus masters onto one |
// | slave, with a per-transaction timeout that completes with an error. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module cmd_arb_rr #(
  parameter int          NUM_MASTERS    = 4,
  parameter int          ADDR_BITS      = 26,
  parameter int          DATA_BITS      = 32,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  localparam int         IDX_W          = $clog2(NUM_MASTERS)
) (
  input  logic             clk,
  input  logic             rst_n,
  cmd_arb_rr_if.slave      cmd,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout_evt
);

  // Counter only has to reach TIMEOUT_CYCLES-1
  localparam int                   CNT_W       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]     C_CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W:0]       C_NUM       = (IDX_W + 1)'(NUM_MASTERS);
  localparam logic [IDX_W-1:0]     C_LAST_IDX  = IDX_W'(NUM_MASTERS - 1);
  localparam logic [DATA_BITS-1:0] C_ERR_RDATA = DATA_BITS'(ERR_RDATA);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_found;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W:0]   w_scan;
  logic [IDX_W-1:0] w_ptr_next;
  logic             w_timeout;

  // Find the first requester at or after the round-robin pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_scan  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_scan = {1'b0, r_ptr} + (IDX_W + 1)'(k);
      if (w_scan >= C_NUM) begin
        w_scan = w_scan - C_NUM;
      end
      if (!w_found && cmd.m_sel[w_scan[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_scan[IDX_W-1:0];
      end
    end
  end

  // Next pointer: the master just served moves to the back of the line
  assign w_ptr_next = (grant_idx == C_LAST_IDX) ? '0 : grant_idx + 1'b1;

  // A timeout of zero means wait forever
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == C_CNT_LAST);

  // Arbitration FSM; every output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_ptr           <= '0;
      r_cnt           <= '0;
      grant_idx       <= '0;
      timeout_evt     <= 1'b0;
      cmd.m_ack       <= '0;
      cmd.m_err       <= '0;
      cmd.m_rdata     <= '0;
      cmd.s_sel       <= 1'b0;
      cmd.s_rd_wr_n   <= 1'b0;
      cmd.s_byte_addr <= '0;
      cmd.s_wdata     <= '0;
    end else begin
      // Completion strobes are single-cycle pulses
      cmd.m_ack   <= '0;
      cmd.m_err   <= '0;
      timeout_evt <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            cmd.s_sel       <= 1'b1;
            cmd.s_rd_wr_n   <= cmd.m_rd_wr_n[w_pick];
            cmd.s_byte_addr <= cmd.m_byte_addr[w_pick*ADDR_BITS +: ADDR_BITS];
            cmd.s_wdata     <= cmd.m_wdata[w_pick*DATA_BITS +: DATA_BITS];
            grant_idx       <= w_pick;
            r_cnt           <= '0;
            r_state         <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          // A real ack wins over a timeout landing in the same cycle
          if (cmd.s_ack) begin
            cmd.m_ack[grant_idx] <= 1'b1;
            cmd.m_rdata          <= cmd.s_rdata;
            cmd.s_sel            <= 1'b0;
            r_ptr                <= w_ptr_next;
            r_state              <= S_DONE;
          end else if (w_timeout) begin
            cmd.m_ack[grant_idx] <= 1'b1;
            cmd.m_err[grant_idx] <= 1'b1;
            cmd.m_rdata          <= C_ERR_RDATA;
            timeout_evt          <= 1'b1;
            cmd.s_sel            <= 1'b0;
            r_ptr                <= w_ptr_next;
            r_state              <= S_DONE;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // One idle cycle so the served master can drop its sel
        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_arb_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cmd_arb_rr                                                        |
// | Self-checking bench for cmd_arb_rr: table-driven single transactions |
// | and hand-written multi-cycle sequences, checked via a scoreboard.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_cmd_arb_rr;
  localparam int NM = 4;
  localparam int AB = 26;
  localparam int DB = 32;
  localparam int TO = 16;
  localparam int IW = 2;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cmd_arb_rr_if #(.NUM_MASTERS(NM), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();
  cmd_arb_rr_if #(.NUM_MASTERS(NM), .ADDR_BITS(AB), .DATA_BITS(DB)) busz ();

  logic [IW-1:0] grant_idx;
  logic          timeout_evt;
  logic [IW-1:0] grant_idx_z;
  logic          timeout_evt_z;

  cmd_arb_rr #(
    .NUM_MASTERS(NM), .ADDR_BITS(AB), .DATA_BITS(DB),
    .TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd(bus),
    .grant_idx(grant_idx), .timeout_evt(timeout_evt)
  );

  // Second instance with the timeout disabled
  cmd_arb_rr #(
    .NUM_MASTERS(NM), .ADDR_BITS(AB), .DATA_BITS(DB),
    .TIMEOUT_CYCLES(0), .ERR_RDATA(32'hDEAD_BEEF)
  ) u_dut_z (
    .clk(clk), .rst_n(rst_n), .cmd(busz),
    .grant_idx(grant_idx_z), .timeout_evt(timeout_evt_z)
  );

  typedef struct {
    int            m;
    logic          rdwr;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
  } txn_t;

  typedef struct {
    int            m;
    logic          rdwr;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
    logic          err;
    logic [DB-1:0] rdata;
    int            cyc;    // s_sel high cycles for this transaction
  } exp_t;

  typedef struct {
    int            m;
    logic          rdwr;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
    int            delay;  // slave ack delay, -1 = never
    logic [DB-1:0] base;   // slave returns base + addr
    logic          err;
    logic [DB-1:0] rdata;
    int            cyc;
  } vec_t;

  exp_t          sb[$];
  txn_t          mq[NM][8];
  int            mq_h[NM];
  int            mq_n[NM];
  int            slv_delay;
  logic [DB-1:0] slv_base;
  bit            stray;
  int            slv_cnt;
  bit            slv_done;
  int            sel_cyc;
  bit            prev_ssel;
  logic [NM-1:0] ack_seen;
  int            ack_count;
  int            ptr_m;
  int            errors;
  int            checks;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic enq(input int m, input logic rdwr, input logic [AB-1:0] addr, input logic [DB-1:0] wdata);
    mq[m][mq_n[m]] = '{m, rdwr, addr, wdata};
    mq_n[m]++;
  endtask

  task automatic push_exp(input int m, input logic rdwr, input logic [AB-1:0] addr,
                          input logic [DB-1:0] wdata, input logic err, input logic [DB-1:0] rdata,
                          input int cyc);
    sb.push_back('{m, rdwr, addr, wdata, err, rdata, cyc});
  endtask

  // Reference round-robin: order of service for everything currently queued
  task automatic push_group();
    int  h[NM];
    int  i;
    bit  any;
    txn_t t;
    for (int j = 0; j < NM; j++) h[j] = mq_h[j];
    do begin
      any = 1'b0;
      for (int k = 0; k < NM; k++) begin
        i = (ptr_m + k) % NM;
        if (!any && h[i] < mq_n[i]) begin
          any = 1'b1;
          t = mq[i][h[i]];
          push_exp(i, t.rdwr, t.addr, t.wdata, 1'b0, slv_base + DB'(t.addr), slv_delay + 1);
          h[i]++;
          ptr_m = (i + 1) % NM;
        end
      end
    end while (any);
  endtask

  function automatic bit pending();
    bit p;
    p = (bus.m_sel != '0);
    for (int i = 0; i < NM; i++) if (mq_h[i] < mq_n[i]) p = 1'b1;
    return p;
  endfunction

  // One clock: observe on the falling edge, then drive masters and slave
  task automatic step();
    exp_t          e;
    logic [NM-1:0] oh;
    logic [NM-1:0] ev;
    @(negedge clk);
    if (bus.s_sel && !prev_ssel) begin
      sel_cyc = 1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_grant: grant_idx=%0d with nothing expected", grant_idx);
      end else begin
        check("grant", {grant_idx, bus.s_rd_wr_n, bus.s_byte_addr, bus.s_wdata},
              {IW'(sb[0].m), sb[0].rdwr, sb[0].addr, sb[0].wdata});
      end
    end else if (bus.s_sel) begin
      sel_cyc++;
    end
    prev_ssel = bus.s_sel;
    ack_seen  = bus.m_ack;
    if (bus.m_ack != '0) begin
      ack_count++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: m_ack=%b with nothing outstanding", bus.m_ack);
      end else begin
        e  = sb.pop_front();
        oh = '0;
        oh[e.m] = 1'b1;
        ev = e.err ? oh : '0;
        check("completion",
              {bus.m_ack, bus.m_err, bus.m_rdata, timeout_evt, grant_idx, 16'(sel_cyc)},
              {oh, ev, e.rdata, e.err, IW'(e.m), 16'(e.cyc)});
      end
    end else if (timeout_evt) begin
      checks++; errors++;
      $display("FAIL lone_timeout_evt: timeout_evt=1 without m_ack");
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < NM; i++) begin
      if (ack_seen[i]) bus.m_sel[i] = 1'b0;
      if (!bus.m_sel[i] && mq_h[i] < mq_n[i]) begin
        bus.m_sel[i]                 = 1'b1;
        bus.m_rd_wr_n[i]             = mq[i][mq_h[i]].rdwr;
        bus.m_byte_addr[i*AB +: AB]  = mq[i][mq_h[i]].addr;
        bus.m_wdata[i*DB +: DB]      = mq[i][mq_h[i]].wdata;
        mq_h[i]++;
      end
    end
    if (stray) begin
      bus.s_ack = 1'b1;
      stray     = 1'b0;
    end else if (bus.s_sel && !slv_done) begin
      if (slv_delay >= 0 && slv_cnt == slv_delay) begin
        bus.s_ack   = 1'b1;
        bus.s_rdata = slv_base + DB'(bus.s_byte_addr);
        slv_done    = 1'b1;
      end else begin
        bus.s_ack = 1'b0;
        slv_cnt++;
      end
    end else begin
      bus.s_ack = 1'b0;
      if (!bus.s_sel) begin
        slv_cnt  = 0;
        slv_done = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || pending()) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0 || pending()) begin
      errors++;
      $display("FAIL %s: not finished in %0d cycles, %0d completions outstanding", name, budget, sb.size());
      sb.delete();
      bus.m_sel = '0;
    end
    for (int i = 0; i < NM; i++) begin
      mq_h[i] = 0;
      mq_n[i] = 0;
    end
    step();
    step();
  endtask

  initial begin
    vec_t vt[6];
    int   acks0;
    bit   zbad;
    int   zsel;

    errors = 0; checks = 0; ack_count = 0; ptr_m = 0;
    stray = 1'b0; slv_delay = -1; slv_base = '0; slv_cnt = 0; slv_done = 1'b0;
    sel_cyc = 0; prev_ssel = 1'b0; ack_seen = '0;
    for (int i = 0; i < NM; i++) begin
      mq_h[i] = 0;
      mq_n[i] = 0;
    end
    rst_n = 1'b0;
    bus.m_sel = '0; bus.m_rd_wr_n = '0; bus.m_byte_addr = '0; bus.m_wdata = '0;
    bus.s_ack = 1'b0; bus.s_rdata = '0;
    busz.m_sel = '0; busz.m_rd_wr_n = '0; busz.m_byte_addr = '0; busz.m_wdata = '0;
    busz.s_ack = 1'b0; busz.s_rdata = '0;

    //             m  rdwr  addr          wdata         dly base          err   rdata         cyc
    vt[0] = '{0, 1'b1, 26'h000_0100, 32'h0000_0000,  2, 32'h1234_5578, 1'b0, 32'h1234_5678,  3};
    vt[1] = '{1, 1'b1, 26'h000_0004, 32'h0000_0000, 15, 32'h1000_0000, 1'b0, 32'h1000_0004, 16};
    vt[2] = '{3, 1'b1, 26'h3FF_FFFC, 32'h0000_0000,  0, 32'h0000_0000, 1'b0, 32'h03FF_FFFC,  1};
    vt[3] = '{0, 1'b0, 26'h000_0020, 32'hCAFE_F00D, 16, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 16};
    vt[4] = '{1, 1'b1, 26'h000_0010, 32'h0000_0000, 14, 32'hFFFF_0000, 1'b0, 32'hFFFF_0010, 15};
    vt[5] = '{2, 1'b0, 26'h123_4560, 32'h0BAD_F00D, -1, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 16};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {bus.m_ack, bus.m_err, bus.m_rdata, bus.s_sel, bus.s_rd_wr_n, bus.s_byte_addr,
           bus.s_wdata, grant_idx, timeout_evt}, 128'd0);
    rst_n = 1'b1;
    step();
    step();

    // Masters 0, 1, 3 re-requesting back to back, slave acks on first cycle
    slv_delay = 0;
    slv_base  = 32'h7700_0000;
    for (int k = 0; k < 2; k++) begin
      enq(0, 1'(k),     26'(32'h040 + 4 * k), 32'h1000_0000 + 32'(k));
      enq(1, 1'(k + 1), 26'(32'h080 + 4 * k), 32'h2000_0000 + 32'(k));
      enq(3, 1'(k),     26'(32'h0C0 + 4 * k), 32'h3000_0000 + 32'(k));
    end
    push_group();
    drain(200, "rr_group");

    // Single transactions from the table
    for (int v = 0; v < 6; v++) begin
      slv_delay = vt[v].delay;
      slv_base  = vt[v].base;
      enq(vt[v].m, vt[v].rdwr, vt[v].addr, vt[v].wdata);
      push_exp(vt[v].m, vt[v].rdwr, vt[v].addr, vt[v].wdata, vt[v].err, vt[v].rdata, vt[v].cyc);
      ptr_m = (vt[v].m + 1) % NM;
      drain(100, "vector");
    end

    // Late ack after the timeout must be ignored; rdata keeps the error word
    acks0 = ack_count;
    stray = 1'b1;
    repeat (4) step();
    check("stray_ack_ignored", 128'(ack_count - acks0), 128'd0);
    check("rdata_hold", bus.m_rdata, 32'hDEAD_BEEF);

    // Reset while master 2 waits on a dead slave
    slv_delay = -1;
    enq(2, 1'b0, 26'h055, 32'h0000_0001);
    push_exp(2, 1'b0, 26'h055, 32'h0000_0001, 1'b0, 32'h0, 0);
    repeat (6) step();
    #2 rst_n = 1'b0;
    #1;
    check("reset_abort",
          {bus.m_ack, bus.m_err, bus.m_rdata, bus.s_sel, bus.s_rd_wr_n, bus.s_byte_addr,
           bus.s_wdata, grant_idx, timeout_evt}, 128'd0);
    sb.delete();
    acks0     = ack_count;
    ptr_m     = 0;
    slv_delay = 3;
    slv_base  = 32'h0A00_0000;
    enq(0, 1'b1, 26'h030, 32'h0);
    push_exp(0, 1'b1, 26'h030, 32'h0, 1'b0, 32'h0A00_0030, 4);
    push_exp(2, 1'b0, 26'h055, 32'h0000_0001, 1'b0, 32'h0A00_0055, 4);
    ptr_m = 3;
    step();
    step();
    check("no_ack_in_reset", 128'(ack_count - acks0), 128'd0);
    rst_n = 1'b1;
    drain(100, "after_reset");

    // Timeout disabled: a 5000-cycle slave still completes normally
    @(posedge clk);
    #1;
    busz.m_sel[1]             = 1'b1;
    busz.m_rd_wr_n[1]         = 1'b1;
    busz.m_byte_addr[AB +: AB] = 26'h044;
    @(posedge clk);
    #1;
    check("z_grant", {busz.s_sel, grant_idx_z, busz.s_byte_addr}, {1'b1, 2'd1, 26'h044});
    zbad = 1'b0;
    zsel = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk);
      #1;
      if (busz.m_ack != '0 || timeout_evt_z) zbad = 1'b1;
      if (busz.s_sel) zsel++;
    end
    check("z_no_timeout", {zbad, 16'(zsel)}, {1'b0, 16'd5000});
    busz.s_ack   = 1'b1;
    busz.s_rdata = 32'h5A5A_1234;
    @(posedge clk);
    #1;
    busz.s_ack = 1'b0;
    check("z_completion", {busz.m_ack, busz.m_err, busz.m_rdata, timeout_evt_z, busz.s_sel},
          {4'b0010, 4'b0000, 32'h5A5A_1234, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    busz.m_sel[1] = 1'b0;
    check("z_single_pulse", {busz.m_ack, busz.m_rdata}, {4'b0000, 32'h5A5A_1234});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
